vd_pm_ctrl: RTL

//  Sequences one Viterbi decode frame around the ACS/path-metric loop: initialises path metrics,

---
 rtl/vd_pkg.sv | 29 ++
 rtl/vd_pm_ctrl_if.sv | 45 ++++
 rtl/vd_pm_min4.sv | 35 +++
 rtl/vd_pm_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vd_pkg.sv
// ============================================================================
// Package     : vd_pkg
// Description : Shared definitions for the Viterbi path-metric controller:
//               FSM state encoding and default widths / normalisation level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vd_pkg;

    // Default configuration values (overridable per instance)
    localparam int VD_LEN_W       = 16;
    localparam int VD_PM_W        = 8;
    localparam int VD_PM_MAX      = (1 << VD_PM_W) - 1;
    localparam int VD_NORM_THRESH = 128;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_RUN      = 3'd2,
        ST_TB_START = 3'd3,
        ST_TB_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vd_pm_ctrl_if.sv
// ============================================================================
// Interface   : vd_pm_ctrl_if
// Description : Symbol handshake and ACSU/PMU/TBU control bundle of the
//               path-metric controller.
//   master modport : controller side (vd_pm_ctrl)
//   slave  modport : datapath / symbol-source side
//   sym_valid_i/sym_ready_o     branch-metric handshake
//   pm_s0_i..pm_s3_i            path metrics fed back from the PMU
//   pm_init_o/pm_update_o       PMU init pulse / per-symbol update strobe
//   norm_sub_o                  amount ACSU subtracts this update
//   tb_start_o/tb_done_i        traceback handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vd_pm_ctrl_if
    import vd_pkg::*;
#(
    parameter int PM_W = VD_PM_W
);
    logic            sym_valid_i;
    logic            sym_ready_o;
    logic [PM_W-1:0] pm_s0_i;
    logic [PM_W-1:0] pm_s1_i;
    logic [PM_W-1:0] pm_s2_i;
    logic [PM_W-1:0] pm_s3_i;
    logic            pm_init_o;
    logic            pm_update_o;
    logic [PM_W-1:0] norm_sub_o;
    logic            tb_start_o;
    logic            tb_done_i;

    modport master (
        input  sym_valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, tb_done_i,
        output sym_ready_o, pm_init_o, pm_update_o, norm_sub_o, tb_start_o
    );

    modport slave (
        output sym_valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, tb_done_i,
        input  sym_ready_o, pm_init_o, pm_update_o, norm_sub_o, tb_start_o
    );

endinterface

`default_nettype wire

// File: rtl/vd_pm_min4.sv
// ============================================================================
// Module      : vd_pm_min4
// Description : Minimum of four unsigned path metrics, two-level compare tree.
//               Only present when VD_PM_NORM_EN is defined; otherwise the
//               controller has no use for it and the module is not built.
//   a_i..d_i  in   PM_W  path metrics
//   min_o     out  PM_W  smallest of the four
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef VD_PM_NORM_EN
module vd_pm_min4
    import vd_pkg::*;
#(
    parameter int PM_W = VD_PM_W
) (
    input  wire logic [PM_W-1:0] a_i,
    input  wire logic [PM_W-1:0] b_i,
    input  wire logic [PM_W-1:0] c_i,
    input  wire logic [PM_W-1:0] d_i,
    output logic      [PM_W-1:0] min_o
);

    logic [PM_W-1:0] w_min_ab;
    logic [PM_W-1:0] w_min_cd;

    assign w_min_ab = (a_i <= b_i) ? a_i : b_i;
    assign w_min_cd = (c_i <= d_i) ? c_i : d_i;
    assign min_o    = (w_min_ab <= w_min_cd) ? w_min_ab : w_min_cd;

endmodule
`endif

`default_nettype wire

// File: rtl/vd_pm_ctrl.sv
// ============================================================================
// Module      : vd_pm_ctrl
// Description : Sequences one Viterbi decode frame: PM init pulse, per-symbol
//               PMU update gating, optional metric normalisation and the
//               traceback handshake at frame end.
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       frame start (sampled in IDLE only)
//   frame_len_i   symbols in frame, latched on accepted start
//   bus           vd_pm_ctrl_if.master (symbol handshake, PMU/ACSU/TBU ctl)
//   step_cnt_o    symbols accepted in current frame
//   busy_o        high in every state but IDLE
//   done_o        one-cycle frame-completion pulse
// Build option: VD_PM_NORM_EN enables min-PM normalisation; undefined ties
//               norm_sub_o to zero and drops the comparator tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vd_pm_ctrl
    import vd_pkg::*;
#(
    parameter int LEN_W       = VD_LEN_W,
    parameter int PM_W        = VD_PM_W,
    parameter int NORM_THRESH = VD_NORM_THRESH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start_i,
    input  wire logic [LEN_W-1:0] frame_len_i,
    vd_pm_ctrl_if.master          bus,
    output logic      [LEN_W-1:0] step_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [LEN_W-1:0] c_one         = LEN_W'(1);
    localparam logic [PM_W-1:0]  c_norm_thresh = PM_W'(NORM_THRESH);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_step;
    logic             r_pm_init;
    logic             r_tb_start;
    logic             r_done;
    logic             w_ready;
    logic             w_accept;

    // Ready is a pure state decode so the symbol source sees it without latency
    assign w_ready  = (r_state == ST_RUN);
    assign w_accept = bus.sym_valid_i & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_step     <= '0;
            r_pm_init  <= 1'b0;
            r_tb_start <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Pulse outputs are set only on the transition into their state
            r_pm_init  <= 1'b0;
            r_tb_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_len  <= frame_len_i;
                        r_step <= '0;
                        if (frame_len_i == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_INIT;
                            r_pm_init <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_step <= r_step + c_one;
                        // r_len is non-zero here, so len-1 cannot underflow
                        if (r_step == r_len - c_one) begin
                            r_state    <= ST_TB_START;
                            r_tb_start <= 1'b1;
                        end
                    end
                end
                ST_TB_START: begin
                    r_state <= ST_TB_WAIT;
                end
                ST_TB_WAIT: begin
                    if (bus.tb_done_i) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sym_ready_o = w_ready;
    assign bus.pm_update_o = w_accept;
    assign bus.pm_init_o   = r_pm_init;
    assign bus.tb_start_o  = r_tb_start;
    assign step_cnt_o      = r_step;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;

`ifdef VD_PM_NORM_EN
    logic [PM_W-1:0] w_min4;

    vd_pm_min4 #(
        .PM_W (PM_W)
    ) u_min4 (
        .a_i   (bus.pm_s0_i),
        .b_i   (bus.pm_s1_i),
        .c_i   (bus.pm_s2_i),
        .d_i   (bus.pm_s3_i),
        .min_o (w_min4)
    );

    // Subtract only on cycles that actually write new metrics into the PMU
    assign bus.norm_sub_o = (w_accept && (w_min4 >= c_norm_thresh)) ? c_norm_thresh : '0;
`else
    logic w_unused_pm;

    assign w_unused_pm    = ^{bus.pm_s0_i, bus.pm_s1_i, bus.pm_s2_i, bus.pm_s3_i, c_norm_thresh};
    assign bus.norm_sub_o = '0;
`endif

endmodule

`default_nettype wire
